// File: rtl/rf_pkg.sv
// Shared types for the register-file write arbiter.
// Holds index/word types, the hard-zero index and arbiter states.
package rf_pkg;

  localparam int REG_IDX_W = 5;
  localparam int ZERO_REG  = 31;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [63:0]          rf_word_t;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans valid_i from ptr_i, wrapping.
// Ports: valid_i, ptr_i in; grant_o (one-hot), idx_o, any_o out.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int idx;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!any_o && valid_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        idx_o        = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port.
// Ports: clk, reset (sync, active-low), req_valid/addr/data in,
// req_ready, write_en, data_in, busy out. RF_CLEAR_SEQ_EN adds a
// post-reset walk that zeroes registers 0..NUM_REGS-2.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][REG_IDX_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REGS-1:0]                write_en,
  output logic [NUM_REGS-1:0][DATA_W-1:0]    data_in,
  output logic                               busy
);

  localparam int PW = $clog2(NUM_REQ);

`ifdef RF_CLEAR_SEQ_EN
  localparam arb_state_e RST_STATE = CLEAR;
`else
  localparam arb_state_e RST_STATE = RUN;
`endif

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [NUM_REGS-1:0]   we_q, we_d;
  logic [DATA_W-1:0]     data_q, data_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [PW-1:0]         pick_idx;
  logic                  pick_any;
  reg_idx_t              win_addr;
  logic                  run;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // No grant may be offered while reset is held.
  assign run       = reset && (state_q == RUN);
  assign req_ready = run ? pick_gnt : '0;
  assign win_addr  = req_addr[pick_idx];
  assign write_en  = we_q;
  assign data_in   = {NUM_REGS{data_q}};

`ifdef RF_CLEAR_SEQ_EN
  reg_idx_t clr_q, clr_d;
  assign busy = (state_q == CLEAR);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = '0;
    data_d  = data_q;
`ifdef RF_CLEAR_SEQ_EN
    clr_d   = clr_q;
    if (state_q == CLEAR) begin
      we_d   = NUM_REGS'(1) << clr_q;
      data_d = '0;
      clr_d  = clr_q + 1'b1;
      if (clr_q == reg_idx_t'(NUM_REGS - 2)) begin
        state_d = RUN;
      end
    end else
`endif
    if (state_q == RUN && pick_any) begin
      ptr_d  = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
      data_d = req_data[pick_idx];
      // The top register is hard-zero: accept, but never enable.
      if (int'(win_addr) < NUM_REGS - 1) begin
        we_d = NUM_REGS'(1) << win_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      we_q    <= '0;
      data_q  <= '0;
`ifdef RF_CLEAR_SEQ_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      data_q  <= data_d;
`ifdef RF_CLEAR_SEQ_EN
      clr_q   <= clr_d;
`endif
    end
  end

endmodule
